// File: rtl/mouse_port.sv
// mouse_port: PS/2 mouse to joystick-port (register 177714) adapter.
// Converts mouse packets into latched direction bits, merges button levels,
// and chooses between mouse and joystick as the source shown on port_data.
// Optional build macro MOUSE_PORT_ACCUM_EN: per-axis 12-bit saturating
// accumulators so slow sub-threshold motion still produces direction steps.
module mouse_port (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic signed [8:0] dx,
  input  logic signed [8:0] dy,
  input  logic              left_btn,
  input  logic              right_btn,
  input  logic [7:0]        joystick,
  input  logic              port_we,
  input  logic [15:0]       port_wdata,
  output logic [15:0]       port_data,
  output logic              mouse_sel
);

  typedef enum logic {OFF = 1'b0, TRACK = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  dir;
  logic [3:0]  dir_nxt;
  logic        sel_nxt;
  logic [15:0] pd_nxt;
  logic        wr_clear;
  logic        pkt_take;
  logic signed [11:0] v_x;
  logic signed [11:0] v_y;
  logic [1:0]  fire_x;
  logic [1:0]  fire_y;

  // Threshold test on an axis value: {negative step, positive step}.
  function automatic logic [1:0] axis_fire(input logic signed [11:0] v);
    logic [1:0] f;
    f[0] = (v >= 12'sd4);
    f[1] = (v <= -12'sd4);
    return f;
  endfunction

`ifdef MOUSE_PORT_ACCUM_EN
  logic signed [11:0] acc_x;
  logic signed [11:0] acc_y;
  logic signed [11:0] acc_x_nxt;
  logic signed [11:0] acc_y_nxt;
  logic signed [12:0] sum_x;
  logic signed [12:0] sum_y;

  // Clamp a 13-bit sum into the 12-bit accumulator range.
  function automatic logic signed [11:0] sat12(input logic signed [12:0] s);
    logic signed [11:0] r;
    if (s > 13'sd2047)
      r = 12'sd2047;
    else if (s < -13'sd2048)
      r = $signed(12'h800);
    else
      r = $signed(s[11:0]);
    return r;
  endfunction

  // Step-adjusted accumulator update: a firing axis consumes one step of 4.
  function automatic logic signed [11:0] acc_step(input logic signed [11:0] v,
                                                  input logic             armed,
                                                  input logic [1:0]       f);
    logic signed [11:0] r;
    r = v;
    if (armed && f[0])
      r = v - 12'sd4;
    else if (armed && f[1])
      r = v + 12'sd4;
    return r;
  endfunction

  assign sum_x = $signed({acc_x[11], acc_x}) + $signed({{4{dx[8]}}, dx});
  assign sum_y = $signed({acc_y[11], acc_y}) + $signed({{4{dy[8]}}, dy});
  assign v_x   = sat12(sum_x);
  assign v_y   = sat12(sum_y);
`else
  assign v_x   = $signed({{3{dx[8]}}, dx});
  assign v_y   = $signed({{3{dy[8]}}, dy});
`endif

  assign fire_x = axis_fire(v_x);
  assign fire_y = axis_fire(v_y);

  // A write always wins over a coincident packet; OFF ignores packets.
  assign wr_clear = port_we && !port_wdata[3];
  assign pkt_take = pkt_valid && !port_we && (state == TRACK);

  // Next-state computation for mode, direction bits, source select and read data.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    sel_nxt   = mouse_sel;
    if (port_we)
      state_nxt = port_wdata[3] ? TRACK : OFF;
    if (wr_clear) begin
      dir_nxt = 4'b0000;
    end else if (pkt_take) begin
      if (!dir[1] && !dir[3]) begin
        dir_nxt[1] = fire_x[0];
        dir_nxt[3] = fire_x[1];
      end
      if (!dir[0] && !dir[2]) begin
        dir_nxt[0] = fire_y[0];
        dir_nxt[2] = fire_y[1];
      end
    end
    if (joystick != 8'h00)
      sel_nxt = 1'b0;
    else if (pkt_valid)
      sel_nxt = 1'b1;
    if (sel_nxt)
      pd_nxt = {9'b0, right_btn, left_btn, 1'b0, dir_nxt};
    else
      pd_nxt = {8'b0, joystick};
  end

`ifdef MOUSE_PORT_ACCUM_EN
  // Accumulators follow every accepted packet, firing or not.
  always_comb begin
    acc_x_nxt = acc_x;
    acc_y_nxt = acc_y;
    if (wr_clear) begin
      acc_x_nxt = '0;
      acc_y_nxt = '0;
    end else if (pkt_take) begin
      acc_x_nxt = acc_step(v_x, !dir[1] && !dir[3], fire_x);
      acc_y_nxt = acc_step(v_y, !dir[0] && !dir[2], fire_y);
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x <= '0;
      acc_y <= '0;
    end else begin
      acc_x <= acc_x_nxt;
      acc_y <= acc_y_nxt;
    end
  end
`endif

  // Mode FSM plus registered outputs; port_data is never a combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      dir       <= 4'b0000;
      mouse_sel <= 1'b0;
      port_data <= 16'h0000;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      mouse_sel <= sel_nxt;
      port_data <= pd_nxt;
    end
  end

endmodule

// File: tb/tb_mouse_port.sv
// tb_mouse_port: directed table-driven bench for mouse_port, plus hand-written
// sequences for reset interaction and accumulation (MOUSE_PORT_ACCUM_EN aware).
module tb_mouse_port;

  logic              clk = 1'b0;
  logic              reset;
  logic              pkt_valid;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic              left_btn;
  logic              right_btn;
  logic [7:0]        joystick;
  logic              port_we;
  logic [15:0]       port_wdata;
  logic [15:0]       port_data;
  logic              mouse_sel;

  int checks   = 0;
  int failures = 0;

  mouse_port dut (
    .clk        (clk),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .dx         (dx),
    .dy         (dy),
    .left_btn   (left_btn),
    .right_btn  (right_btn),
    .joystick   (joystick),
    .port_we    (port_we),
    .port_wdata (port_wdata),
    .port_data  (port_data),
    .mouse_sel  (mouse_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [15:0]       wd;
    logic              pv;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic              l;
    logic              r;
    logic [7:0]        joy;
    logic [15:0]       exp_d;
    logic              exp_s;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic we, input logic [15:0] wd, input logic pv,
                              input int vx, input int vy, input logic l, input logic r,
                              input logic [7:0] joy, input logic [15:0] ed, input logic es);
    vec_t v;
    v.we = we; v.wd = wd; v.pv = pv;
    v.dx = 9'(vx); v.dy = 9'(vy);
    v.l = l; v.r = r; v.joy = joy;
    v.exp_d = ed; v.exp_s = es;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [15:0] wd, input logic pv,
                       input int vx, input int vy, input logic l, input logic r,
                       input logic [7:0] joy);
    port_we = we; port_wdata = wd; pkt_valid = pv;
    dx = 9'(vx); dy = 9'(vy);
    left_btn = l; right_btn = r; joystick = joy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 16'h0000, 0, 0, 0, 0, 0, 8'h00);
    check("reset_data", port_data, 16'h0000);
    check("reset_sel", {15'b0, mouse_sel}, 16'h0000);
    reset = 1'b0;

    //  we  wdata     pv  dx    dy   l  r  joy     data      sel
    add(1, 16'h0008, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 0);
    add(0, 16'h0000, 1,    5,   0,  0, 0, 8'h00, 16'h0002, 1);
    add(0, 16'h0000, 0,    0,   0,  0, 0, 8'h00, 16'h0002, 1);
    add(0, 16'h0000, 1,   -9,   0,  0, 0, 8'h00, 16'h0002, 1);
    add(0, 16'h0000, 1,    0,  -4,  0, 0, 8'h00, 16'h0006, 1);
    add(1, 16'h0000, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(0, 16'h0000, 1,    0,   9,  0, 0, 8'h00, 16'h0000, 1);
    add(1, 16'h0008, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(0, 16'h0000, 1,    3,  -3,  0, 0, 8'h00, 16'h0000, 1);
    add(1, 16'h0000, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(1, 16'h0008, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(0, 16'h0000, 1,    4,   4,  1, 0, 8'h00, 16'h0023, 1);
    add(0, 16'h0000, 0,    0,   0,  0, 1, 8'h00, 16'h0043, 1);
    add(1, 16'h0000, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(1, 16'h0008, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(0, 16'h0000, 1,    0,   0,  0, 0, 8'h11, 16'h0011, 0);
    add(0, 16'h0000, 1,    0,   0,  1, 0, 8'h00, 16'h0020, 1);
    add(1, 16'h0008, 1,    0, 100,  0, 0, 8'h00, 16'h0000, 1);
    add(1, 16'h0000, 1,    5,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(0, 16'h0000, 1,    5,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(1, 16'h0008, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 1);
    add(0, 16'h0000, 1, -256, 255,  0, 0, 8'h00, 16'h0009, 1);
    add(0, 16'h0000, 0,    0,   0,  0, 0, 8'h80, 16'h0080, 0);
    add(0, 16'h0000, 0,    0,   0,  0, 0, 8'h00, 16'h0000, 0);
    add(0, 16'h0000, 1,    0,   0,  0, 0, 8'h00, 16'h0009, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].wd, tbl[i].pv, int'(tbl[i].dx), int'(tbl[i].dy),
            tbl[i].l, tbl[i].r, tbl[i].joy);
      check($sformatf("vec%0d_data", i), port_data, tbl[i].exp_d);
      check($sformatf("vec%0d_sel", i), {15'b0, mouse_sel}, {15'b0, tbl[i].exp_s});
    end

    // Three slow +2 packets on X.
    drive(1, 16'h0000, 0, 0, 0, 0, 0, 8'h00);
    drive(1, 16'h0008, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 16'h0000, 1, 2, 0, 0, 0, 8'h00);
    check("acc_pkt1", port_data, 16'h0000);
    drive(0, 16'h0000, 1, 2, 0, 0, 0, 8'h00);
`ifdef MOUSE_PORT_ACCUM_EN
    check("acc_pkt2", port_data, 16'h0002);
    check("acc_x_pkt2", 16'($unsigned(dut.acc_x)), 16'h0000);
`else
    check("acc_pkt2", port_data, 16'h0000);
`endif
    drive(0, 16'h0000, 1, 2, 0, 0, 0, 8'h00);
`ifdef MOUSE_PORT_ACCUM_EN
    check("acc_pkt3", port_data, 16'h0002);
    check("acc_x_pkt3", 16'($unsigned(dut.acc_x)), 16'h0002);
`else
    check("acc_pkt3", port_data, 16'h0000);
`endif

    // Saturation: X negative bit set, then 20 large negative packets.
    drive(1, 16'h0000, 0, 0, 0, 0, 0, 8'h00);
    drive(1, 16'h0008, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 16'h0000, 1, -4, 0, 0, 0, 8'h00);
    check("sat_arm", port_data, 16'h0008);
    for (int k = 0; k < 20; k++)
      drive(0, 16'h0000, 1, -256, 0, 0, 0, 8'h00);
    check("sat_data", port_data, 16'h0008);
`ifdef MOUSE_PORT_ACCUM_EN
    check("sat_acc_x", 16'($unsigned(dut.acc_x)), 16'h0800);
`endif

    // Reset overrides a coincident write and packet.
    reset = 1'b1;
    drive(1, 16'h0008, 1, 5, 0, 0, 0, 8'h00);
    check("rst_override_data", port_data, 16'h0000);
    check("rst_override_sel", {15'b0, mouse_sel}, 16'h0000);
    reset = 1'b0;
    drive(0, 16'h0000, 1, 5, 0, 0, 0, 8'h00);
    check("post_rst_pkt_data", port_data, 16'h0000);
    check("post_rst_pkt_sel", {15'b0, mouse_sel}, 16'h0001);
    drive(1, 16'h0008, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 16'h0000, 1, 5, 0, 0, 0, 8'h00);
    check("post_rst_track", port_data, 16'h0002);

    drive(0, 16'h0000, 0, 0, 0, 0, 0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
